// File: rtl/ftl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ftl_pkg                                                          |
// | Purpose  : shared types and constants for the FTL address responder.        |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package ftl_pkg;

   localparam int c_ADDR_WIDTH  = 32;
   localparam int c_PAGE_SHIFT  = 14;
   localparam int c_NUM_LPAGES  = 256;
   localparam int c_NUM_PPAGES  = 512;

   // Table entries are sized for the default physical log depth.
   localparam int c_ENTRY_PPN_W = $clog2(c_NUM_PPAGES);

   localparam logic c_READ  = 1'b0;
   localparam logic c_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      UPDATE = 2'd2,
      RESP   = 2'd3
   } ftl_state_e;

   typedef struct packed {
      logic                     valid;
      logic [c_ENTRY_PPN_W-1:0] ppn;
   } l2p_entry_t;

endpackage
`default_nettype wire

// File: rtl/ftl_addr_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ftl_addr_responder_if                                            |
// | Purpose  : four-phase address-translation handshake between the burst       |
// |            controller (master) and the FTL responder (slave).               |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface ftl_addr_responder_if
   import ftl_pkg::*;
#(
   parameter int ADDR_WIDTH = c_ADDR_WIDTH
);
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  addr_valid;
   logic                  mem_rw;
   logic [ADDR_WIDTH-1:0] mem_new_address;
   logic                  addr_resp;
   logic                  cache_hit;

   modport master (
      output mem_address, addr_valid, mem_rw,
      input  mem_new_address, addr_resp, cache_hit
   );

   modport slave (
      input  mem_address, addr_valid, mem_rw,
      output mem_new_address, addr_resp, cache_hit
   );
endinterface
`default_nettype wire

// File: rtl/ftl_l2p_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ftl_l2p_table                                                    |
// | Purpose  : logical-to-physical page table, one registered read port and     |
// |            one write port; valid bits clear asynchronously on reset.        |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ftl_l2p_table
   import ftl_pkg::*;
#(
   parameter int NUM_LPAGES = c_NUM_LPAGES,
   parameter int LPN_W      = $clog2(NUM_LPAGES)
) (
   input  wire                   clk_i,
   input  wire                   rst_ni,
   input  wire                   rd_en,
   input  wire       [LPN_W-1:0] rd_lpn,
   output l2p_entry_t            rd_entry,
   input  wire                   wr_en,
   input  wire       [LPN_W-1:0] wr_lpn,
   input  wire l2p_entry_t       wr_entry
);

   logic [NUM_LPAGES-1:0]    r_valid;
   logic [c_ENTRY_PPN_W-1:0] r_ppn [NUM_LPAGES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
      end else if (wr_en) begin
         r_valid[wr_lpn] <= wr_entry.valid;
      end
   end

   // Page numbers are only meaningful behind a valid bit, so they need no reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         r_ppn[wr_lpn] <= wr_entry.ppn;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_entry <= '0;
      end else if (rd_en) begin
         rd_entry.valid <= r_valid[rd_lpn];
         rd_entry.ppn   <= r_ppn[rd_lpn];
      end
   end

endmodule
`default_nettype wire

// File: rtl/ftl_addr_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ftl_addr_responder                                               |
// | Purpose  : translates logical byte addresses to physical ones through an    |
// |            L2P table; writes go out-of-place to a circular page log.        |
// |            Define FTL_STATS_EN to add saturating read/write/hit counters.   |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ftl_addr_responder
   import ftl_pkg::*;
#(
   parameter int ADDR_WIDTH = c_ADDR_WIDTH,
   parameter int PAGE_SHIFT = c_PAGE_SHIFT,
   parameter int NUM_LPAGES = c_NUM_LPAGES,
   parameter int NUM_PPAGES = c_NUM_PPAGES
) (
   input  wire                  clk_i,
   input  wire                  rst_ni,
   ftl_addr_responder_if.slave  bus,
   output logic                 map_err_o,
   output logic                 log_wrap_o
`ifdef FTL_STATS_EN
   ,
   output logic [31:0]          stat_rd_o,
   output logic [31:0]          stat_wr_o,
   output logic [31:0]          stat_hit_o
`endif
);

   localparam int c_LPN_W    = $clog2(NUM_LPAGES);
   localparam int c_PPN_BITS = $clog2(NUM_PPAGES);
   localparam logic [c_PPN_BITS-1:0] c_PPN_LAST    = c_PPN_BITS'(NUM_PPAGES - 1);
   localparam logic [ADDR_WIDTH-1:0] c_LADDR_LIMIT = ADDR_WIDTH'(NUM_LPAGES) << PAGE_SHIFT;

   if (c_PPN_BITS + PAGE_SHIFT > ADDR_WIDTH) begin : g_bad_phys_width
      $error("ftl_addr_responder: physical page number plus offset exceeds ADDR_WIDTH");
   end
   if (c_LPN_W + PAGE_SHIFT > ADDR_WIDTH) begin : g_bad_log_width
      $error("ftl_addr_responder: logical page number plus offset exceeds ADDR_WIDTH");
   end
   if (c_PPN_BITS > c_ENTRY_PPN_W) begin : g_bad_entry_width
      $error("ftl_addr_responder: NUM_PPAGES too large for l2p_entry_t");
   end

   ftl_state_e              r_state;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_rw;
   logic                    r_err;
   logic [c_PPN_BITS-1:0]   r_wr_ptr;
   logic [c_PPN_BITS-1:0]   r_alloc_ppn;
   logic [ADDR_WIDTH-1:0]   r_mem_new_address;
   logic                    r_addr_resp;
   logic                    r_cache_hit;

   l2p_entry_t              w_rd_entry;
   l2p_entry_t              w_wr_entry;
   logic                    w_rd_en;
   logic                    w_wr_en;
   logic [c_LPN_W-1:0]      w_lpn;
   logic [PAGE_SHIFT-1:0]   w_offset;
   logic                    w_out_of_range;
   logic [ADDR_WIDTH-1:0]   w_resp_addr;
   logic                    w_resp_hit;
   logic                    w_resp_done;

   assign w_lpn          = r_addr[PAGE_SHIFT +: c_LPN_W];
   assign w_offset       = r_addr[PAGE_SHIFT-1:0];
   assign w_out_of_range = (r_addr >= c_LADDR_LIMIT);
   assign w_rd_en        = (r_state == LOOKUP);
   assign w_wr_en        = (r_state == UPDATE);
   assign w_wr_entry     = '{valid: 1'b1, ppn: c_ENTRY_PPN_W'(r_wr_ptr)};
   assign w_resp_done    = (r_state == RESP) && !bus.addr_valid;

   ftl_l2p_table #(
      .NUM_LPAGES (NUM_LPAGES),
      .LPN_W      (c_LPN_W)
   ) u_l2p_table (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .rd_en    (w_rd_en),
      .rd_lpn   (w_lpn),
      .rd_entry (w_rd_entry),
      .wr_en    (w_wr_en),
      .wr_lpn   (w_lpn),
      .wr_entry (w_wr_entry)
   );

   // The table read port is only enabled in LOOKUP, so w_rd_entry still holds
   // the pre-update entry while a write sits in RESP.
   always_comb begin
      w_resp_addr = '0;
      w_resp_hit  = 1'b0;
      if (!r_err) begin
         if (r_rw == c_WRITE) begin
            w_resp_addr = ADDR_WIDTH'({r_alloc_ppn, w_offset});
            w_resp_hit  = w_rd_entry.valid;
         end else if (w_rd_entry.valid) begin
            w_resp_addr = ADDR_WIDTH'({w_rd_entry.ppn[c_PPN_BITS-1:0], w_offset});
            w_resp_hit  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state           <= IDLE;
         r_addr            <= '0;
         r_rw              <= c_READ;
         r_err             <= 1'b0;
         r_wr_ptr          <= '0;
         r_alloc_ppn       <= '0;
         r_mem_new_address <= '0;
         r_addr_resp       <= 1'b0;
         r_cache_hit       <= 1'b0;
         map_err_o         <= 1'b0;
         log_wrap_o        <= 1'b0;
      end else begin
         map_err_o  <= 1'b0;
         log_wrap_o <= 1'b0;
         case (r_state)
            IDLE: begin
               r_addr_resp       <= 1'b0;
               r_mem_new_address <= '0;
               r_cache_hit       <= 1'b0;
               if (bus.addr_valid) begin
                  r_addr  <= bus.mem_address;
                  r_rw    <= bus.mem_rw;
                  r_state <= LOOKUP;
               end
            end
            LOOKUP: begin
               r_err <= w_out_of_range;
               if (w_out_of_range) begin
                  map_err_o <= 1'b1;
                  r_state   <= RESP;
               end else if (r_rw == c_WRITE) begin
                  r_state <= UPDATE;
               end else begin
                  r_state <= RESP;
               end
            end
            UPDATE: begin
               r_alloc_ppn <= r_wr_ptr;
               r_wr_ptr    <= r_wr_ptr + 1'b1;
               log_wrap_o  <= (r_wr_ptr == c_PPN_LAST);
               r_state     <= RESP;
            end
            RESP: begin
               // Re-registered every cycle; inputs are stable so the values hold.
               r_addr_resp       <= 1'b1;
               r_mem_new_address <= w_resp_addr;
               r_cache_hit       <= w_resp_hit;
               if (!bus.addr_valid) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mem_new_address = r_mem_new_address;
   assign bus.addr_resp       = r_addr_resp;
   assign bus.cache_hit       = r_cache_hit;

`ifdef FTL_STATS_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_rd_o  <= '0;
         stat_wr_o  <= '0;
         stat_hit_o <= '0;
      end else if (w_resp_done) begin
         if (r_rw == c_READ && stat_rd_o != '1) begin
            stat_rd_o <= stat_rd_o + 32'd1;
         end
         if (r_rw == c_WRITE && stat_wr_o != '1) begin
            stat_wr_o <= stat_wr_o + 32'd1;
         end
         if (w_resp_hit && stat_hit_o != '1) begin
            stat_hit_o <= stat_hit_o + 32'd1;
         end
      end
   end
`else
   logic w_unused_stats;
   assign w_unused_stats = w_resp_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ftl_addr_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ftl_addr_responder                                            |
// | Purpose  : randomized self-checking bench against a page-table model.       |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ftl_addr_responder;

   localparam int PS = 14;
   localparam int NL = 256;
   localparam int NP = 512;

   logic clk_i;
   logic rst_ni;
   logic map_err_o;
   logic log_wrap_o;
`ifdef FTL_STATS_EN
   logic [31:0] stat_rd_o, stat_wr_o, stat_hit_o;
`endif

   ftl_addr_responder_if #(.ADDR_WIDTH(32)) bus ();

   ftl_addr_responder u_dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .bus        (bus),
      .map_err_o  (map_err_o),
      .log_wrap_o (log_wrap_o)
`ifdef FTL_STATS_EN
      ,
      .stat_rd_o  (stat_rd_o),
      .stat_wr_o  (stat_wr_o),
      .stat_hit_o (stat_hit_o)
`endif
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_bad    = 0;

   // Reference model: what each logical page currently points at.
   bit          mdl_valid [NL];
   int unsigned mdl_ppn   [NL];
   int unsigned mdl_ptr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < NL; i++) begin
         mdl_valid[i] = 1'b0;
         mdl_ppn[i]   = 0;
      end
      mdl_ptr = 0;
   endtask

   task automatic do_req(input logic [31:0] addr, input logic rw, input bit early,
                         output logic [31:0] got_addr);
      int unsigned lpn, off, exp_lat;
      logic [31:0] exp_addr;
      bit          exp_hit, exp_err, exp_wrap, seen;
      int          lat, n_err, n_wrap;

      lpn      = addr >> PS;
      off      = addr & ((1 << PS) - 1);
      exp_err  = (lpn >= NL);
      exp_addr = '0;
      exp_hit  = 1'b0;
      exp_wrap = 1'b0;
      if (!exp_err) begin
         if (rw) begin
            exp_addr       = (mdl_ptr << PS) | off;
            exp_hit        = mdl_valid[lpn];
            exp_wrap       = (mdl_ptr == NP - 1);
            mdl_valid[lpn] = 1'b1;
            mdl_ppn[lpn]   = mdl_ptr;
            mdl_ptr        = (mdl_ptr + 1) % NP;
         end else if (mdl_valid[lpn]) begin
            exp_addr = (mdl_ppn[lpn] << PS) | off;
            exp_hit  = 1'b1;
         end
      end
      exp_lat = (rw && !exp_err) ? 3 : 2;

      @(negedge clk_i);
      bus.mem_address = addr;
      bus.mem_rw      = rw;
      bus.addr_valid  = 1'b1;
      seen = 0; lat = -1; n_err = 0; n_wrap = 0;
      got_addr = '0;
      // i counts edges after the one that samples addr_valid.
      for (int i = 0; i < 12 && !seen; i++) begin
         @(posedge clk_i); #1;
         if (map_err_o)  n_err++;
         if (log_wrap_o) n_wrap++;
         if (bus.addr_resp) begin
            seen = 1;
            lat  = i;
         end else if (early && i == 0) begin
            bus.addr_valid = 1'b0;
         end
      end
      if (!seen) begin
         check("resp_timeout", 32'd0, 32'd1);
         bus.addr_valid = 1'b0;
         repeat (4) @(posedge clk_i);
         #1;
         return;
      end
      got_addr = bus.mem_new_address;
      check("resp_addr", bus.mem_new_address, exp_addr);
      check("resp_hit",  32'(bus.cache_hit), 32'(exp_hit));
      check("resp_lat",  32'(lat), exp_lat);
      if (!early) begin
         bus.addr_valid = 1'b0;
         @(posedge clk_i); #1;
         if (map_err_o)  n_err++;
         if (log_wrap_o) n_wrap++;
         check("resp_hold",      32'(bus.addr_resp), 32'd1);
         check("resp_hold_addr", bus.mem_new_address, exp_addr);
      end
      @(posedge clk_i); #1;
      if (map_err_o)  n_err++;
      if (log_wrap_o) n_wrap++;
      check("resp_clear", 32'(bus.addr_resp), 32'd0);
      check("map_err_cnt",  32'(n_err),  32'(exp_err));
      check("log_wrap_cnt", 32'(n_wrap), 32'(exp_wrap));
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_resp"}, 32'(bus.addr_resp), 32'd0);
      check({tag, "_addr"}, bus.mem_new_address, 32'd0);
      check({tag, "_hit"},  32'(bus.cache_hit), 32'd0);
      check({tag, "_err"},  32'(map_err_o), 32'd0);
      check({tag, "_wrap"}, 32'(log_wrap_o), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a, got;
      logic        rw;
      bit          early;
      int unsigned lpn;

      rst_ni          = 1'b0;
      bus.mem_address = '0;
      bus.mem_rw      = 1'b0;
      bus.addr_valid  = 1'b0;
      mdl_clear();
      repeat (3) @(posedge clk_i);
      #1;
      check_idle_outputs("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      check_idle_outputs("post_reset");

      // Directed walk through first write, hit, overwrite, miss, range error.
      do_req(32'h0000_8010, 1'b1, 1'b0, got);
      do_req(32'h0000_8020, 1'b0, 1'b0, got);
      do_req(32'h0000_8000, 1'b1, 1'b0, got);
      do_req(32'h0000_C000, 1'b0, 1'b0, got);
      do_req(32'h0040_0000, 1'b0, 1'b0, got);
      do_req(32'h0040_0000, 1'b1, 1'b0, got);
      do_req(32'h0000_8000, 1'b0, 1'b0, got);
      do_req(32'h0000_4abc, 1'b1, 1'b1, got);
      do_req(32'h0000_4abc, 1'b0, 1'b1, got);

      for (int n = 0; n < 300; n++) begin
         lpn = $urandom_range(0, NL + 7);
         a   = (lpn << PS) | ($urandom & ((1 << PS) - 1));
         if ($urandom_range(0, 15) == 0) a = $urandom;
         rw    = $urandom_range(0, 1) == 1;
         early = $urandom_range(0, 7) == 0;
         do_req(a, rw, early, got);
      end

      // Reset asserted while the write is in UPDATE must leave nothing behind.
      do_req(32'h0000_8000, 1'b1, 1'b0, got);
      @(negedge clk_i);
      bus.mem_address = 32'h0001_0000;
      bus.mem_rw      = 1'b1;
      bus.addr_valid  = 1'b1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      bus.addr_valid = 1'b0;
      mdl_clear();
      @(negedge clk_i);
      rst_ni = 1'b1;
      do_req(32'h0000_8000, 1'b0, 1'b0, got);
      do_req(32'h0001_0000, 1'b0, 1'b0, got);

      // Fill the whole log: wrap on write 512, write 513 reuses page 0.
      for (int n = 0; n < NP + 1; n++) begin
         a = ($urandom_range(0, NL - 1) << PS) | ($urandom & ((1 << PS) - 1));
         do_req(a, 1'b1, 1'b0, got);
         if (n == NP) check("wrap_ppn0", got >> PS, 32'd0);
      end
      for (int n = 0; n < 20; n++) begin
         a = ($urandom_range(0, NL - 1) << PS) | ($urandom & ((1 << PS) - 1));
         do_req(a, 1'b0, 1'b0, got);
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
